// File: rtl/pic_host_pkg.sv
// Shared types and constants for the 8259 PIC host-side bus master.
package pic_host_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic A0_CMD  = 1'b0;
  localparam logic A0_DATA = 1'b1;

  // OCW3 codes that select which status register the next read returns
  localparam logic [7:0] OCW3_READ_IRR = 8'h0A;
  localparam logic [7:0] OCW3_READ_ISR = 8'h0B;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_ACK1,
    ST_ACK_GAP,
    ST_ACK2,
    ST_ACK_DONE
  } state_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pic_host_master_timer.sv
// Loadable down-counter; done is high whenever the count sits at zero.
module pic_strobe_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (cnt != '0)
      cnt <= cnt - 1'b1;
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/pic_host_master.sv
// 8259 PIC host master: CPU read/write bus cycles plus automatic two-pulse
// INTA servicing with vector capture.
//
// state      | meaning
// -----------+-----------------------------------------------
// IDLE       | bus quiet, accepting commands or INT
// SETUP      | cs_n low, a0/db set up, strobes high
// STROBE     | wr_n or rd_n low for STROBE_CYCLES
// HOLD       | strobes released, cs_n low, read result valid
// ACK1       | first INTA pulse
// ACK_GAP    | INTA high between pulses
// ACK2       | second INTA pulse, vector sampled at its end
// ACK_DONE   | vector valid pulse
module pic_host_master
  import pic_host_pkg::*;
#(
  parameter int STROBE_CYCLES = 2,
  parameter int GAP_CYCLES    = 1,
  parameter int DATA_W        = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_rd,
  input  logic              cmd_a0,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              ack_en,
  input  logic              pic_int,
  output logic              vec_valid,
  output logic [DATA_W-1:0] vec_data,
  output logic              busy,
  output logic              cs_n,
  output logic              wr_n,
  output logic              rd_n,
  output logic              a0,
  output logic              inta_n,
  output logic [DATA_W-1:0] db_out,
  output logic              db_oe,
  input  logic [DATA_W-1:0] db_in
);

  localparam int CNT_W = cnt_width(STROBE_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD    = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic             lat_rd;
  logic             ack_req;
  logic             tmr_load;
  logic             tmr_done;
  logic [CNT_W-1:0] tmr_val;

  assign ack_req   = ack_en && pic_int;
  assign cmd_ready = (state == ST_IDLE) && !ack_req;
  assign busy      = (state != ST_IDLE);

  // Timer is loaded on the edge that enters a timed state
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = STROBE_LOAD;
    case (state)
      ST_IDLE:    tmr_load = ack_req;
      ST_SETUP:   tmr_load = 1'b1;
      ST_ACK1: begin
        tmr_load = tmr_done;
        tmr_val  = GAP_LOAD;
      end
      ST_ACK_GAP: tmr_load = tmr_done;
      default:    tmr_load = 1'b0;
    endcase
  end

  pic_strobe_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      lat_rd    <= 1'b0;
      cs_n      <= 1'b1;
      wr_n      <= 1'b1;
      rd_n      <= 1'b1;
      a0        <= A0_CMD;
      inta_n    <= 1'b1;
      db_out    <= '0;
      db_oe     <= 1'b0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      vec_valid <= 1'b0;
      vec_data  <= '0;
    end else begin
      rd_valid  <= 1'b0;
      vec_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ack_req) begin
            state  <= ST_ACK1;
            inta_n <= 1'b0;
          end else if (cmd_valid) begin
            state  <= ST_SETUP;
            lat_rd <= cmd_rd;
            cs_n   <= 1'b0;
            a0     <= cmd_a0;
            db_out <= cmd_wdata;
            db_oe  <= !cmd_rd;
          end
        end
        ST_SETUP: begin
          state <= ST_STROBE;
          wr_n  <= lat_rd;
          rd_n  <= !lat_rd;
        end
        ST_STROBE: begin
          if (tmr_done) begin
            state <= ST_HOLD;
            wr_n  <= 1'b1;
            rd_n  <= 1'b1;
            if (lat_rd) begin
              rd_data  <= db_in;
              rd_valid <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          db_oe <= 1'b0;
        end
        ST_ACK1: begin
          if (tmr_done) begin
            state  <= ST_ACK_GAP;
            inta_n <= 1'b1;
          end
        end
        ST_ACK_GAP: begin
          if (tmr_done) begin
            state  <= ST_ACK2;
            inta_n <= 1'b0;
          end
        end
        ST_ACK2: begin
          if (tmr_done) begin
            state     <= ST_ACK_DONE;
            inta_n    <= 1'b1;
            vec_data  <= db_in;
            vec_valid <= 1'b1;
          end
        end
        ST_ACK_DONE: state <= ST_IDLE;
        default:     state <= ST_IDLE;
      endcase
    end
  end

endmodule
